// File: rtl/vx_local_mem_ctrl.sv
// Local memory model for the Vortex mem_req/mem_rsp interface: byte-lane RAM,
// fixed-latency read pipeline, in-order response FIFO, and credit-based request flow control.
module vx_local_mem_ctrl #(
   parameter int DATA_WIDTH = 512,
   parameter int ADDR_WIDTH = 26,
   parameter int TAG_WIDTH  = 56,
   parameter int MEM_WORDS  = 4096,
   parameter int LATENCY    = 2,
   parameter int RSP_DEPTH  = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    mem_req_valid,
   input  logic                    mem_req_rw,
   input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
   input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
   input  logic [DATA_WIDTH-1:0]   mem_req_data,
   input  logic [TAG_WIDTH-1:0]    mem_req_tag,
   output logic                    mem_req_ready,
   output logic                    mem_rsp_valid,
   output logic [DATA_WIDTH-1:0]   mem_rsp_data,
   output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
   input  logic                    mem_rsp_ready,
   output logic                    busy,
   output logic                    tb_addr_out_of_bounds
);

   localparam int NUM_BYTES = DATA_WIDTH / 8;
   localparam int IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int PTR_W     = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CNT_W     = $clog2(RSP_DEPTH + 1);

   localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_WORDS);
   localparam logic [CNT_W-1:0]    DEPTH_C   = CNT_W'(RSP_DEPTH);
   localparam logic [PTR_W-1:0]    LAST_PTR  = PTR_W'(RSP_DEPTH - 1);

   logic                  req_fire;
   logic                  rd_fire;
   logic                  wr_fire;
   logic                  rsp_fire;
   logic                  in_bounds;
   logic [IDX_W-1:0]      mem_idx;
   logic [DATA_WIDTH-1:0] rd_line;

   logic [CNT_W-1:0]      inflight_reg;
   logic [CNT_W-1:0]      inflight_next;
   logic                  oob_reg;

   logic [LATENCY-1:0]    pipe_valid_reg;
   logic [LATENCY-1:0]    pipe_zero_reg;
   logic [TAG_WIDTH-1:0]  pipe_tag_reg [LATENCY];
   logic [DATA_WIDTH-1:0] exit_data;
   logic                  push;
   logic [DATA_WIDTH-1:0] push_data;
   logic [TAG_WIDTH-1:0]  push_tag;

   logic [DATA_WIDTH-1:0] fifo_data_reg [RSP_DEPTH];
   logic [TAG_WIDTH-1:0]  fifo_tag_reg  [RSP_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_reg;
   logic [PTR_W-1:0]      wr_ptr_next;
   logic [PTR_W-1:0]      rd_ptr_reg;
   logic [PTR_W-1:0]      rd_ptr_next;
   logic [CNT_W-1:0]      count_reg;
   logic [CNT_W-1:0]      count_next;

   // Requests presented while reset is held are ignored so memory is never touched then.
   assign mem_req_ready = (inflight_reg < DEPTH_C);
   assign req_fire      = mem_req_valid && mem_req_ready && reset;
   assign rd_fire       = req_fire && !mem_req_rw;
   assign in_bounds     = ({1'b0, mem_req_addr} < MEM_LIMIT);
   assign wr_fire       = req_fire && mem_req_rw && in_bounds;
   assign mem_idx       = mem_req_addr[IDX_W-1:0];

   // One 8-bit RAM per byte lane gives byte-enabled writes with a plain registered read port.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
         logic [7:0] lane_mem [MEM_WORDS];
         logic [7:0] lane_rd_reg;

         always_ff @(posedge clk) begin
            if (wr_fire && mem_req_byteen[gi]) begin
               lane_mem[mem_idx] <= mem_req_data[gi*8 +: 8];
            end
            if (rd_fire) begin
               lane_rd_reg <= lane_mem[mem_idx];
            end
         end

         assign rd_line[gi*8 +: 8] = lane_rd_reg;
      end
   endgenerate

   // Stage 0 data lives in the lane read registers; later stages are explicit delay registers.
   generate
      if (LATENCY > 1) begin : g_dly
         logic [DATA_WIDTH-1:0] dly_reg [LATENCY-1];

         always_ff @(posedge clk) begin
            dly_reg[0] <= rd_line;
            for (int i = 1; i < LATENCY - 1; i++) begin
               dly_reg[i] <= dly_reg[i-1];
            end
         end

         assign exit_data = dly_reg[LATENCY-2];
      end else begin : g_nodly
         assign exit_data = rd_line;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!reset) begin
         pipe_valid_reg <= '0;
      end else begin
         pipe_valid_reg[0] <= rd_fire;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_valid_reg[i] <= pipe_valid_reg[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      pipe_tag_reg[0]  <= mem_req_tag;
      pipe_zero_reg[0] <= !in_bounds;
      for (int i = 1; i < LATENCY; i++) begin
         pipe_tag_reg[i]  <= pipe_tag_reg[i-1];
         pipe_zero_reg[i] <= pipe_zero_reg[i-1];
      end
   end

   // Out-of-range reads still flow through the pipeline but surface as all-zero lines.
   assign push      = pipe_valid_reg[LATENCY-1];
   assign push_tag  = pipe_tag_reg[LATENCY-1];
   assign push_data = pipe_zero_reg[LATENCY-1] ? '0 : exit_data;

   assign mem_rsp_valid = (count_reg != '0);
   assign mem_rsp_data  = mem_rsp_valid ? fifo_data_reg[rd_ptr_reg] : '0;
   assign mem_rsp_tag   = mem_rsp_valid ? fifo_tag_reg[rd_ptr_reg] : '0;
   assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;

   always_comb begin
      inflight_next = inflight_reg;
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      count_next    = count_reg;

      if (rd_fire && !rsp_fire) begin
         inflight_next = inflight_reg + 1'b1;
      end else if (!rd_fire && rsp_fire) begin
         inflight_next = inflight_reg - 1'b1;
      end

      if (push) begin
         wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (rsp_fire) begin
         rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
      end

      if (push && !rsp_fire) begin
         count_next = count_reg + 1'b1;
      end else if (!push && rsp_fire) begin
         count_next = count_reg - 1'b1;
      end
   end

   // Credits cover pipeline plus queue, so a push never finds the queue full.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data_reg[wr_ptr_reg] <= push_data;
         fifo_tag_reg[wr_ptr_reg]  <= push_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         inflight_reg <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         oob_reg      <= 1'b0;
      end else begin
         inflight_reg <= inflight_next;
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         count_reg    <= count_next;
         if (req_fire && !in_bounds) begin
            oob_reg <= 1'b1;
         end
      end
   end

   assign busy                  = (inflight_reg != '0);
   assign tb_addr_out_of_bounds = oob_reg;

endmodule

// File: tb/tb_vx_local_mem_ctrl.sv
// Scoreboard bench for vx_local_mem_ctrl: a line-level memory model predicts every response,
// and an independent monitor pops and compares whenever a response handshake occurs.
module tb_vx_local_mem_ctrl;

   localparam int DW    = 512;
   localparam int AW    = 26;
   localparam int TW    = 56;
   localparam int MW    = 4096;
   localparam int LAT   = 2;
   localparam int DEPTH = 4;
   localparam int BW    = DW / 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          mem_req_valid;
   logic          mem_req_rw;
   logic [BW-1:0] mem_req_byteen;
   logic [AW-1:0] mem_req_addr;
   logic [DW-1:0] mem_req_data;
   logic [TW-1:0] mem_req_tag;
   logic          mem_req_ready;
   logic          mem_rsp_valid;
   logic [DW-1:0] mem_rsp_data;
   logic [TW-1:0] mem_rsp_tag;
   logic          mem_rsp_ready;
   logic          busy;
   logic          tb_addr_out_of_bounds;

   int total = 0;
   int bad   = 0;
   bit rand_mode = 1'b0;

   logic [DW-1:0] ref_mem [int];
   logic [DW-1:0] exp_data_q [$];
   logic [TW-1:0] exp_tag_q [$];
   logic [DW-1:0] mon_data;
   logic [TW-1:0] mon_tag;

   always #5 clk = ~clk;

   vx_local_mem_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .TAG_WIDTH  (TW),
      .MEM_WORDS  (MW),
      .LATENCY    (LAT),
      .RSP_DEPTH  (DEPTH)
   ) dut (
      .clk                   (clk),
      .reset                 (reset),
      .mem_req_valid         (mem_req_valid),
      .mem_req_rw            (mem_req_rw),
      .mem_req_byteen        (mem_req_byteen),
      .mem_req_addr          (mem_req_addr),
      .mem_req_data          (mem_req_data),
      .mem_req_tag           (mem_req_tag),
      .mem_req_ready         (mem_req_ready),
      .mem_rsp_valid         (mem_rsp_valid),
      .mem_rsp_data          (mem_rsp_data),
      .mem_rsp_tag           (mem_rsp_tag),
      .mem_rsp_ready         (mem_rsp_ready),
      .busy                  (busy),
      .tb_addr_out_of_bounds (tb_addr_out_of_bounds)
   );

   // Response monitor: every handshake must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (reset === 1'b1 && mem_rsp_valid === 1'b1 && mem_rsp_ready === 1'b1) begin
         total++;
         if (exp_tag_q.size() == 0) begin
            bad++;
            $display("FAIL rsp_unexpected: got tag=%0h data[63:0]=%0h, required no response", mem_rsp_tag, mem_rsp_data[63:0]);
         end else begin
            mon_data = exp_data_q.pop_front();
            mon_tag  = exp_tag_q.pop_front();
            if (mem_rsp_data !== mon_data || mem_rsp_tag !== mon_tag) begin
               bad++;
               $display("FAIL rsp_match: got tag=%0h data=%h, required tag=%0h data=%h", mem_rsp_tag, mem_rsp_data, mon_tag, mon_data);
            end else begin
               $display("rsp tag=%0h data[63:0]=%0h ok", mem_rsp_tag, mem_rsp_data[63:0]);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] rand_line();
      logic [DW-1:0] l;
      for (int i = 0; i < DW / 32; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   function automatic logic [BW-1:0] rand_be();
      logic [BW-1:0] b;
      for (int i = 0; i < BW; i++) b[i] = 1'($urandom_range(0, 1));
      return b;
   endfunction

   // Reference behaviour: writes merge enabled bytes into the line, reads snapshot the line now.
   task automatic model_accept(input bit rw, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input logic [BW-1:0] be, input logic [TW-1:0] tag);
      logic [DW-1:0] line;
      int a;
      a = int'(addr);
      if (rw) begin
         if (a < MW) begin
            line = ref_mem.exists(a) ? ref_mem[a] : '0;
            for (int b = 0; b < BW; b++) begin
               if (be[b]) line[b*8 +: 8] = data[b*8 +: 8];
            end
            ref_mem[a] = line;
         end
      end else begin
         line = (a < MW && ref_mem.exists(a)) ? ref_mem[a] : '0;
         exp_data_q.push_back(line);
         exp_tag_q.push_back(tag);
      end
   endtask

   // Present a request from just after a rising edge until accepted; returns cycles waited.
   task automatic issue(input bit rw, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [BW-1:0] be, input logic [TW-1:0] tag,
                        input int max_wait, output int waited);
      bit ok;
      int w;
      ok = 1'b0;
      w = 0;
      waited = -1;
      mem_req_valid  = 1'b1;
      mem_req_rw     = rw;
      mem_req_addr   = addr;
      mem_req_data   = data;
      mem_req_byteen = be;
      mem_req_tag    = tag;
      while (!ok && w < max_wait) begin
         @(negedge clk);
         if (mem_req_ready === 1'b1) begin
            ok = 1'b1;
            waited = w;
            model_accept(rw, addr, data, be, tag);
         end
         tick();
         if (rand_mode) mem_rsp_ready = 1'($urandom_range(0, 1));
         w++;
      end
      mem_req_valid = 1'b0;
      $display("req rw=%0d addr=%0h tag=%0h waited=%0d", rw, addr, tag, waited);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL req_accept: tag=%0h not accepted, required acceptance within %0d cycles", tag, max_wait);
      end
   endtask

   task automatic drain(input int max_cycles);
      int n;
      n = 0;
      mem_rsp_ready = 1'b1;
      while (exp_tag_q.size() != 0 && n < max_cycles) begin
         tick();
         n++;
      end
      tick();
      @(negedge clk);
      chk("drain_empty", 64'(exp_tag_q.size()), 64'd0);
      chk("drain_busy", 64'(busy), 64'd0);
      tick();
   endtask

   initial begin
      int waited;
      logic [BW-1:0] be_all;
      logic [BW-1:0] be_low4;
      logic [DW-1:0] d;
      logic [63:0]   r64;
      logic [AW-1:0] a;
      bit            rw;

      be_all  = '1;
      be_low4 = '0;
      be_low4[3:0] = 4'hF;

      reset          = 1'b0;
      mem_req_valid  = 1'b0;
      mem_req_rw     = 1'b0;
      mem_req_byteen = '0;
      mem_req_addr   = '0;
      mem_req_data   = '0;
      mem_req_tag    = '0;
      mem_rsp_ready  = 1'b0;

      // Reset, then idle
      tick();
      tick();
      reset = 1'b1;
      @(negedge clk);
      chk("rst_ready", 64'(mem_req_ready), 64'd1);
      chk("rst_rsp_valid", 64'(mem_rsp_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_oob", 64'(tb_addr_out_of_bounds), 64'd0);
      chk("rst_rsp_data_zero", 64'(mem_rsp_data != '0), 64'd0);
      chk("rst_rsp_tag", 64'(mem_rsp_tag), 64'd0);
      tick();

      // Byte-enabled writes, then a read timed against the latency
      mem_rsp_ready = 1'b1;
      issue(1'b1, AW'(5), {BW{8'hAA}}, be_all, '0, 4, waited);
      issue(1'b1, AW'(5), {BW{8'h55}}, be_low4, '0, 4, waited);
      issue(1'b0, AW'(5), '0, '0, TW'(3), 4, waited);
      @(negedge clk);
      chk("lat_after_edge0", 64'(mem_rsp_valid), 64'd0);
      tick();
      @(negedge clk);
      chk("lat_after_edge1", 64'(mem_rsp_valid), 64'd0);
      tick();
      @(negedge clk);
      chk("lat_after_edge2", 64'(mem_rsp_valid), 64'd1);
      chk("lat_rsp_tag", 64'(mem_rsp_tag), 64'h3);
      tick();
      drain(20);

      // Fill lines 0..15 with random contents for the later reads
      for (int i = 0; i < 16; i++) begin
         issue(1'b1, AW'(i), rand_line(), be_all, '0, 4, waited);
      end

      // Backpressure: only DEPTH reads fit while responses are stalled
      mem_rsp_ready = 1'b0;
      for (int i = 1; i <= DEPTH; i++) begin
         issue(1'b0, AW'(i), '0, '0, TW'(i), 1, waited);
      end
      mem_req_valid = 1'b1;
      mem_req_rw    = 1'b0;
      mem_req_addr  = AW'(5);
      mem_req_tag   = TW'(5);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_ready_low", 64'(mem_req_ready), 64'd0);
         chk("bp_busy", 64'(busy), 64'd1);
         tick();
      end
      mem_rsp_ready = 1'b1;
      issue(1'b0, AW'(5), '0, '0, TW'(5), 20, waited);
      issue(1'b0, AW'(6), '0, '0, TW'(6), 20, waited);
      drain(40);

      // Streaming: one read accepted every cycle
      for (int i = 0; i < 16; i++) begin
         issue(1'b0, AW'(i), '0, '0, TW'(100 + i), 1, waited);
         chk("stream_no_stall", 64'(waited), 64'd0);
      end
      drain(40);

      // Out-of-bounds: the write aliasing line 0 must be dropped, the read returns zero
      @(negedge clk);
      chk("oob_before", 64'(tb_addr_out_of_bounds), 64'd0);
      tick();
      issue(1'b1, AW'(MW), rand_line(), be_all, '0, 4, waited);
      @(negedge clk);
      chk("oob_set", 64'(tb_addr_out_of_bounds), 64'd1);
      tick();
      issue(1'b0, AW'(0), '0, '0, TW'(8'h21), 4, waited);
      issue(1'b0, AW'(MW + 1), '0, '0, TW'(9), 4, waited);
      drain(20);
      chk("oob_sticky", 64'(tb_addr_out_of_bounds), 64'd1);

      // Randomised mix with a toggling response consumer
      rand_mode = 1'b1;
      for (int k = 0; k < 80; k++) begin
         rw  = ($urandom_range(0, 2) == 0);
         a   = ($urandom_range(0, 9) == 0) ? AW'(MW + $urandom_range(0, 50)) : AW'($urandom_range(0, 15));
         r64 = {$urandom, $urandom};
         d   = rand_line();
         issue(rw, a, d, rand_be(), r64[TW-1:0], 60, waited);
         if ($urandom_range(0, 3) == 0) tick();
      end
      rand_mode = 1'b0;
      drain(60);

      // Reset with reads in flight: nothing may come out afterwards
      mem_rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         issue(1'b0, AW'(7 + i), '0, '0, TW'(8'h40 + i), 4, waited);
      end
      tick();
      reset = 1'b0;
      exp_data_q.delete();
      exp_tag_q.delete();
      tick();
      @(negedge clk);
      chk("mid_rst_rsp_valid", 64'(mem_rsp_valid), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_ready", 64'(mem_req_ready), 64'd1);
      chk("mid_rst_oob", 64'(tb_addr_out_of_bounds), 64'd0);
      tick();
      reset = 1'b1;
      mem_rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_rst_no_stale", 64'(mem_rsp_valid), 64'd0);
         tick();
      end
      issue(1'b0, AW'(3), '0, '0, TW'(8'h77), 4, waited);
      drain(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
